// File: rtl/sop_gen_mc_if.sv
// sop_gen_mc_if: shared interleaved stream bus observed by the start-of-packet
// generator. One beat per cycle, tagged with the channel it belongs to.
//   valid : beat present on the bus
//   ready : sink accepts the beat (handshake = valid & ready)
//   last  : beat is the final beat of its packet
//   ch    : channel id of the beat
// master drives the bus (stream source plus sink ready), slave only observes it.
interface sop_gen_mc_if #(
  parameter int CH_W = 2
);
  logic            valid;
  logic            ready;
  logic            last;
  logic [CH_W-1:0] ch;

  modport master (
    output valid,
    output ready,
    output last,
    output ch
  );

  modport slave (
    input valid,
    input ready,
    input last,
    input ch
  );
endinterface

// File: rtl/sop_gen_mc.sv
// sop_gen_mc: multi-channel start-of-packet generator for an interleaved
// valid/ready stream. Tracks per-channel packet framing, flags the first beat
// of each packet, reports the beat index within the packet and truncates
// packets that reach MAX_BEATS beats.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   bus         : shared stream bus (valid, ready, last, ch), slave view
//   flush_i     : synchronous clear of all channel framing state
//   sop_o       : current beat is the first beat of a packet (combinational)
//   eop_o       : current beat ends its packet, by last or by length limit
//   beat_idx_o  : index of the current beat within its packet (combinational)
//   in_pkt_o    : per-channel mid-packet flags (registered)
//   len_err_o   : one-cycle pulse, a packet was truncated at MAX_BEATS
//   err_ch_o    : channel of the most recent length error
module sop_gen_mc #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  sop_gen_mc_if.slave       bus,
  input  logic              flush_i,
  output logic              sop_o,
  output logic              eop_o,
  output logic [CNT_W-1:0]  beat_idx_o,
  output logic [NUM_CH-1:0] in_pkt_o,
  output logic              len_err_o,
  output logic [CH_W-1:0]   err_ch_o
);

  logic [NUM_CH-1:0] in_pkt_q, in_pkt_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic              len_err_q, len_err_d;
  logic [CH_W-1:0]   err_ch_q, err_ch_d;

  logic              chValid;
  logic              curInPkt;
  logic [CNT_W-1:0]  curCnt;
  logic              beatAct;
  logic              limit;
  logic              handshake;

  // Select the addressed channel's state. Ids at or above NUM_CH match no
  // channel, which leaves chValid low and makes the beat invisible.
  always_comb begin
    chValid  = 1'b0;
    curInPkt = 1'b0;
    curCnt   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.ch == CH_W'(c)) begin
        chValid  = 1'b1;
        curInPkt = in_pkt_q[c];
        curCnt   = cnt_q[c];
      end
    end
  end

  // Beat qualification does not need ready, so a stalled first beat keeps
  // sop_o asserted until it is finally accepted.
  always_comb begin
    beatAct    = bus.valid & chValid;
    beat_idx_o = (chValid & curInPkt) ? curCnt : '0;
    limit      = (beat_idx_o == CNT_W'(MAX_BEATS - 1));
    sop_o      = beatAct & ~curInPkt;
    eop_o      = beatAct & (bus.last | limit);
    handshake  = beatAct & bus.ready;
  end

  // Next-state: flush overrides any accepted beat, and only the addressed
  // channel moves. A non-last beat at the limit closes the packet and errors.
  always_comb begin
    in_pkt_d  = in_pkt_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    err_ch_d  = err_ch_q;
    if (flush_i) begin
      in_pkt_d = '0;
      for (int c = 0; c < NUM_CH; c++) cnt_d[c] = '0;
    end else if (handshake) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.ch == CH_W'(c)) begin
          if (bus.last || limit) begin
            in_pkt_d[c] = 1'b0;
            cnt_d[c]    = '0;
          end else begin
            in_pkt_d[c] = 1'b1;
            cnt_d[c]    = beat_idx_o + 1'b1;
          end
        end
      end
      if (!bus.last && limit) begin
        len_err_d = 1'b1;
        err_ch_d  = bus.ch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      len_err_q <= 1'b0;
      err_ch_q  <= '0;
    end else begin
      in_pkt_q  <= in_pkt_d;
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
      len_err_q <= len_err_d;
      err_ch_q  <= err_ch_d;
    end
  end

  assign in_pkt_o  = in_pkt_q;
  assign len_err_o = len_err_q;
  assign err_ch_o  = err_ch_q;

endmodule

// File: tb/tb_sop_gen_mc.sv
// tb_sop_gen_mc: self-checking bench for sop_gen_mc with NUM_CH=3 (so id 3 is
// an invalid channel) and MAX_BEATS=4 (so the length limit is reachable).
// A reference model predicts each beat's outputs; predictions are queued when
// the beat is driven and popped when the DUT outputs are sampled.
module tb_sop_gen_mc;

  localparam int NUM_CH    = 3;
  localparam int CH_W      = 2;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 2;

  typedef struct {
    logic             sop;
    logic             eop;
    logic [CNT_W-1:0] idx;
  } combExp_t;

  typedef struct {
    logic [NUM_CH-1:0] inPkt;
    logic              lenErr;
    logic [CH_W-1:0]   errCh;
  } regExp_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              sop;
  logic              eop;
  logic [CNT_W-1:0]  beatIdx;
  logic [NUM_CH-1:0] inPkt;
  logic              lenErr;
  logic [CH_W-1:0]   errCh;

  sop_gen_mc_if #(.CH_W(CH_W)) busIf ();

  sop_gen_mc #(
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W),
    .MAX_BEATS (MAX_BEATS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (busIf.slave),
    .flush_i    (flush),
    .sop_o      (sop),
    .eop_o      (eop),
    .beat_idx_o (beatIdx),
    .in_pkt_o   (inPkt),
    .len_err_o  (lenErr),
    .err_ch_o   (errCh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  combExp_t combQ[$];
  regExp_t  regQ[$];

  // Reference model state
  logic [NUM_CH-1:0] mInPkt;
  int                mCnt [NUM_CH];
  logic              mLenErr;
  logic [CH_W-1:0]   mErrCh;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    mInPkt = '0;
    for (int c = 0; c < NUM_CH; c++) mCnt[c] = 0;
  endtask

  task automatic popAndCheckReg(input string tag);
    regExp_t r;
    if (regQ.size() == 0) begin
      checkOutput({tag, "_regq_empty"}, 32'd1, 32'd0);
    end else begin
      r = regQ.pop_front();
      checkOutput({tag, "_in_pkt"}, 32'(inPkt), 32'(r.inPkt));
      checkOutput({tag, "_len_err"}, 32'(lenErr), 32'(r.lenErr));
      checkOutput({tag, "_err_ch"}, 32'(errCh), 32'(r.errCh));
    end
  endtask

  // Drive one cycle of stimulus, predict the combinational and registered
  // results, then compare against the DUT as it produces them.
  task automatic applyStimulus(input string tag, input logic v, input logic r,
                               input logic l, input logic [CH_W-1:0] c,
                               input logic f, input logic rs);
    combExp_t ce;
    combExp_t got;
    regExp_t  re;
    bit       chOk;
    bit       cur;
    int       idx;
    bit       lim;

    @(negedge clk);
    busIf.valid = v;
    busIf.ready = r;
    busIf.last  = l;
    busIf.ch    = c;
    flush       = f;
    rst         = rs;

    chOk   = (int'(c) < NUM_CH);
    cur    = chOk ? mInPkt[c] : 1'b0;
    idx    = (chOk && cur) ? mCnt[c] : 0;
    lim    = (idx == MAX_BEATS - 1);
    ce.sop = v && chOk && !cur;
    ce.eop = v && chOk && (l || lim);
    ce.idx = CNT_W'(idx);
    combQ.push_back(ce);

    // State prediction for the coming edge
    if (rs) begin
      modelClear();
      mLenErr = 1'b0;
      mErrCh  = '0;
    end else if (f) begin
      modelClear();
      mLenErr = 1'b0;
    end else if (v && r && chOk) begin
      mLenErr = 1'b0;
      if (l) begin
        mInPkt[c] = 1'b0;
        mCnt[c]   = 0;
      end else if (lim) begin
        mInPkt[c] = 1'b0;
        mCnt[c]   = 0;
        mLenErr   = 1'b1;
        mErrCh    = c;
      end else begin
        mInPkt[c] = 1'b1;
        mCnt[c]   = idx + 1;
      end
    end else begin
      mLenErr = 1'b0;
    end
    re.inPkt  = mInPkt;
    re.lenErr = mLenErr;
    re.errCh  = mErrCh;
    regQ.push_back(re);

    #2;
    if (combQ.size() == 0) begin
      checkOutput({tag, "_combq_empty"}, 32'd1, 32'd0);
    end else begin
      got = combQ.pop_front();
      checkOutput({tag, "_sop"}, 32'(sop), 32'(got.sop));
      checkOutput({tag, "_eop"}, 32'(eop), 32'(got.eop));
      checkOutput({tag, "_idx"}, 32'(beatIdx), 32'(got.idx));
    end

    @(posedge clk);
    #1;
    popAndCheckReg(tag);
  endtask

  task automatic applyReset();
    regExp_t re;
    rst         = 1'b1;
    flush       = 1'b0;
    busIf.valid = 1'b0;
    busIf.ready = 1'b0;
    busIf.last  = 1'b0;
    busIf.ch    = '0;
    modelClear();
    mLenErr = 1'b0;
    mErrCh  = '0;
    re.inPkt  = '0;
    re.lenErr = 1'b0;
    re.errCh  = '0;
    regQ.push_back(re);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    popAndCheckReg("reset");
  endtask

  initial begin
    applyReset();

    // Single-channel packet of three beats
    applyStimulus("c0_b0", 1, 1, 0, 2'd0, 0, 0);
    applyStimulus("c0_b1", 1, 1, 0, 2'd0, 0, 0);
    applyStimulus("c0_b2", 1, 1, 1, 2'd0, 0, 0);
    applyStimulus("idle",  0, 0, 0, 2'd0, 0, 0);

    // Interleaved channels: A0,B0,A1,B1(last),A2(last)
    applyStimulus("il_a0", 1, 1, 0, 2'd1, 0, 0);
    applyStimulus("il_b0", 1, 1, 0, 2'd2, 0, 0);
    applyStimulus("il_a1", 1, 1, 0, 2'd1, 0, 0);
    applyStimulus("il_b1", 1, 1, 1, 2'd2, 0, 0);
    applyStimulus("il_a2", 1, 1, 1, 2'd1, 0, 0);

    // Stalled first beat, then accepted, then closed
    for (int i = 0; i < 4; i++) applyStimulus("stall", 1, 0, 0, 2'd0, 0, 0);
    applyStimulus("stall_acc", 1, 1, 0, 2'd0, 0, 0);
    applyStimulus("stall_end", 1, 1, 1, 2'd0, 0, 0);

    // Overlong packet on ch2 is truncated at beat 3, beat 4 starts anew
    for (int i = 0; i < 5; i++) applyStimulus("long", 1, 1, 0, 2'd2, 0, 0);
    applyStimulus("long_end", 1, 1, 1, 2'd2, 0, 0);
    // Exactly MAX_BEATS beats with last at the limit is legal
    for (int i = 0; i < 3; i++) applyStimulus("full", 1, 1, 0, 2'd2, 0, 0);
    applyStimulus("full_last", 1, 1, 1, 2'd2, 0, 0);
    applyStimulus("full_after", 0, 0, 0, 2'd2, 0, 0);

    // Back-to-back truncations on ch1 then ch0
    for (int i = 0; i < 3; i++) applyStimulus("bb1", 1, 1, 0, 2'd1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("bb0", 1, 1, 0, 2'd0, 0, 0);
    applyStimulus("bb1_lim", 1, 1, 0, 2'd1, 0, 0);
    applyStimulus("bb0_lim", 1, 1, 0, 2'd0, 0, 0);
    applyStimulus("bb_idle", 0, 0, 0, 2'd0, 0, 0);

    // Flush during an accepted ch0 beat at index 2, even at the limit setup
    applyStimulus("fl_b0", 1, 1, 0, 2'd0, 0, 0);
    applyStimulus("fl_b1", 1, 1, 0, 2'd0, 0, 0);
    applyStimulus("fl_hit", 1, 1, 0, 2'd0, 1, 0);
    applyStimulus("fl_next", 1, 1, 0, 2'd0, 0, 0);
    applyStimulus("fl_end", 1, 1, 1, 2'd0, 0, 0);
    // Flush must also suppress a would-be length error
    for (int i = 0; i < 3; i++) applyStimulus("fl_lim", 1, 1, 0, 2'd1, 0, 0);
    applyStimulus("fl_lim_hit", 1, 1, 0, 2'd1, 1, 0);

    // Invalid channel id is ignored while ch1 is mid-packet
    applyStimulus("inv_open", 1, 1, 0, 2'd1, 0, 0);
    applyStimulus("inv_ch3", 1, 1, 0, 2'd3, 0, 0);
    applyStimulus("inv_ch3_last", 1, 1, 1, 2'd3, 0, 0);
    applyStimulus("inv_cont", 1, 1, 0, 2'd1, 0, 0);

    // Reset mid-packet on ch1 with a beat present drops framing
    applyStimulus("rst_mid", 1, 1, 0, 2'd1, 0, 1);
    applyStimulus("rst_next", 1, 1, 0, 2'd1, 0, 0);
    applyStimulus("rst_end", 1, 1, 1, 2'd1, 0, 0);

    if (combQ.size() != 0 || regQ.size() != 0)
      checkOutput("queues_drained", 32'(combQ.size() + regQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
